msdf_mult_stream: RTL and testbench

- Parametrised radix-2 online (MSD-first) signed-digit multiplier. Successor to the fixed-width msdf_mult.
- Operands are N-digit fractions in (-1,1). They arrive one digit per accepted cycle, most significant first, and the product is emitted as a signed-digit stream after online delay DELTA.
- Replaces msdf_mult's three ad-hoc valid strobes with a first/valid/ready handshake. Adds bubble tolerance, restart, a flush phase, a sticky error flag and optional product negation.

---
 rtl/msdf_pkg.sv | 26 ++
 rtl/msdf_selm.sv | 21 ++
 rtl/msdf_mult_stream.sv | 204 ++++++++++++++++++++
 tb/tb_msdf_mult_stream.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/msdf_pkg.sv
// Shared definitions for the radix-2 online (MSD-first) arithmetic blocks.
// Latency: none (constants and types only).
// Backpressure: not applicable.
package msdf_pkg;

    // Signed-digit encoding: bit1 = plus, bit0 = minus.
    localparam logic [1:0] DIG_ZERO = 2'b00;
    localparam logic [1:0] DIG_NEG  = 2'b01;
    localparam logic [1:0] DIG_POS  = 2'b10;
    localparam logic [1:0] DIG_BAD  = 2'b11;

    // Online delay the selection function below is built for.
    localparam int MSDF_DELTA = 3;

    // Residual estimate: 2 integer + 2 fraction bits, in units of 1/4.
    localparam int                          SELM_EST_W  = 4;
    localparam logic signed [SELM_EST_W-1:0] SELM_POS_TH = 4'sb0010;  // +1/2
    localparam logic signed [SELM_EST_W-1:0] SELM_NEG_TH = 4'sb1110;  // -1/2

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2
    } state_t;

endpackage

// File: rtl/msdf_selm.sv
// Online digit selection: maps a truncated residual estimate to a signed digit.
// Latency: combinational.
// Backpressure: none; pure function of v_hat.
// Ports: v_hat = residual estimate (2 int + 2 frac bits), p_d = selected digit.
module msdf_selm
    import msdf_pkg::*;
(
    input  logic signed [SELM_EST_W-1:0] v_hat,
    output logic        [1:0]            p_d
);

    always_comb begin
        p_d = DIG_ZERO;
        if (v_hat >= SELM_POS_TH) begin
            p_d = DIG_POS;
        end else if (v_hat < SELM_NEG_TH) begin
            p_d = DIG_NEG;
        end
    end

endmodule

// File: rtl/msdf_mult_stream.sv
// Radix-2 online signed-digit multiplier, one operand digit pair per accepted cycle.
// Latency: p_k appears the cycle after digit k+DELTA is accepted; last DELTA digits from flush.
// Backpressure: in_ready drops only during the DELTA flush cycles; output has no ready.
// Ports: in_valid/in_first/x_d/y_d/neg in, in_ready out; out_valid/out_first/out_last/p_d out;
//        busy = operation in progress, err = sticky illegal-digit flag.
module msdf_mult_stream
    import msdf_pkg::*;
#(
    parameter int N      = 8,
    parameter int DELTA  = 3,
    parameter bit NEG_EN = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic       in_first,
    input  logic [1:0] x_d,
    input  logic [1:0] y_d,
    input  logic       neg,
    output logic       in_ready,
    output logic       out_valid,
    output logic       out_first,
    output logic       out_last,
    output logic [1:0] p_d,
    output logic       busy,
    output logic       err
);

    if (DELTA != MSDF_DELTA) begin : g_bad_delta
        $error("msdf_mult_stream: DELTA must be 3");
    end
    if (N < 4 || N > 32) begin : g_bad_n
        $error("msdf_mult_stream: N must be in 4..32");
    end

    // Residual: 2 integer bits, F fraction bits. Operands: sign + N fraction bits.
    localparam int F       = N + DELTA + 2;
    localparam int W       = F + 2;
    localparam int JW      = $clog2(N + DELTA + 1);
    localparam int TERM_SH = F - N - DELTA;   // aligns 2^-N operand LSB, scaled by 2^-DELTA

    localparam logic signed [W-1:0] ONE_W       = W'(1) <<< F;
    localparam logic signed [N:0]   QM_INIT     = {1'b1, {N{1'b0}}};  // -1: Q - 2^0 with Q = 0
    localparam logic [JW-1:0]       K_FIRST_OUT = JW'(DELTA + 1);
    localparam logic [JW-1:0]       K_LAST_IN   = JW'(N);
    localparam logic [JW-1:0]       J_FLUSH_END = JW'(N + DELTA - 1);

    function automatic logic signed [W-1:0] sext(input logic signed [N:0] a);
        sext = {{(W-N-1){a[N]}}, a};
    endfunction

    state_t                state_q, state_nxt;
    logic [JW-1:0]         j_q;
    logic signed [N:0]     xq_q, xqm_q, yq_q, yqm_q;
    logic signed [W-1:0]   w_q;
    logic                  neg_q, err_q;
    logic                  out_valid_q, out_first_q, out_last_q;
    logic [1:0]            p_q;

    logic                  accept, start, load_step, flush_step, emit, neg_eff;
    logic [1:0]            x_ok, y_ok, xs, ys, p_sel;
    logic [JW-1:0]         j_b, k;
    logic [N:0]            mask;
    logic signed [N:0]     xq_b, xqm_b, yq_b, yqm_b, xq_n, xqm_n, yq_n, yqm_n;
    logic signed [W-1:0]   w_b, tx, ty, term, v, w_n;
    logic signed [SELM_EST_W-1:0] v_hat;

    assign accept     = in_valid && in_ready;
    assign start      = accept && in_first;   // from IDLE, or a restart from LOAD
    assign load_step  = accept && !in_first && (state_q == LOAD);
    assign flush_step = (state_q == FLUSH);

    // A start (including restart) begins from a cleared residual and operands.
    assign j_b   = start ? '0 : j_q;
    assign xq_b  = start ? '0 : xq_q;
    assign xqm_b = start ? QM_INIT : xqm_q;
    assign yq_b  = start ? '0 : yq_q;
    assign yqm_b = start ? QM_INIT : yqm_q;
    assign w_b   = start ? '0 : w_q;
    assign k     = j_b + 1'b1;

    assign neg_eff = NEG_EN && (start ? neg : neg_q);

    always_comb begin
        x_ok = (x_d == DIG_BAD) ? DIG_ZERO : x_d;
        y_ok = (y_d == DIG_BAD) ? DIG_ZERO : y_d;
        // Negating every x digit yields -X, hence -X*Y.
        if (neg_eff) begin
            x_ok = {x_ok[0], x_ok[1]};
        end
        xs   = DIG_ZERO;
        ys   = DIG_ZERO;
        mask = '0;
        if (start || load_step) begin
            xs   = x_ok;
            ys   = y_ok;
            mask = (N+1)'(1) << (N - int'(k));
        end
    end

    // On-the-fly conversion: Q and QM = Q - 2^-k, each updated by appending one bit.
    always_comb begin
        unique case (xs)
            DIG_POS: begin xq_n = xq_b  | mask; xqm_n = xq_b;         end
            DIG_NEG: begin xq_n = xqm_b | mask; xqm_n = xqm_b;        end
            default: begin xq_n = xq_b;         xqm_n = xqm_b | mask; end
        endcase
        unique case (ys)
            DIG_POS: begin yq_n = yq_b  | mask; yqm_n = yq_b;         end
            DIG_NEG: begin yq_n = yqm_b | mask; yqm_n = yqm_b;        end
            default: begin yq_n = yq_b;         yqm_n = yqm_b | mask; end
        endcase
    end

    // Increment of X*Y at step k is X[k-1]*y_k + Y[k]*x_k.
    always_comb begin
        tx = '0;
        ty = '0;
        if (ys == DIG_POS) tx = sext(xq_b);
        if (ys == DIG_NEG) tx = -sext(xq_b);
        if (xs == DIG_POS) ty = sext(yq_n);
        if (xs == DIG_NEG) ty = -sext(yq_n);
        term = (tx + ty) <<< TERM_SH;
        v    = (w_b <<< 1) + term;
    end

    assign v_hat = v[W-1 -: SELM_EST_W];

    msdf_selm u_selm (
        .v_hat (v_hat),
        .p_d   (p_sel)
    );

    // The first DELTA steps only accumulate; selection starts at step DELTA+1.
    assign emit = (load_step && (k >= K_FIRST_OUT)) || flush_step;

    always_comb begin
        w_n = v;
        if (emit && p_sel == DIG_POS) w_n = v - ONE_W;
        if (emit && p_sel == DIG_NEG) w_n = v + ONE_W;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        in_ready  = (state_q != FLUSH);
        busy      = (state_q != IDLE);
        unique case (state_q)
            IDLE:    if (start) state_nxt = LOAD;
            LOAD:    if (load_step && k == K_LAST_IN) state_nxt = FLUSH;
            FLUSH:   if (j_q == J_FLUSH_END) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            j_q         <= '0;
            xq_q        <= '0;
            xqm_q       <= '0;
            yq_q        <= '0;
            yqm_q       <= '0;
            w_q         <= '0;
            neg_q       <= 1'b0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
            p_q         <= DIG_ZERO;
        end else begin
            if (accept && (x_d == DIG_BAD || y_d == DIG_BAD)) err_q <= 1'b1;
            if (start) neg_q <= neg;
            if (start || load_step) begin
                j_q   <= k;
                xq_q  <= xq_n;
                xqm_q <= xqm_n;
                yq_q  <= yq_n;
                yqm_q <= yqm_n;
                w_q   <= w_n;
            end else if (flush_step) begin
                j_q <= j_q + 1'b1;
                w_q <= w_n;
            end
            out_valid_q <= emit;
            p_q         <= emit ? p_sel : DIG_ZERO;
            out_first_q <= load_step && (k == K_FIRST_OUT);
            out_last_q  <= flush_step && (j_q == J_FLUSH_END);
        end
    end

    assign out_valid = out_valid_q;
    assign out_first = out_first_q;
    assign out_last  = out_last_q;
    assign p_d       = p_q;
    assign err       = err_q;

endmodule

// File: tb/tb_msdf_mult_stream.sv
// Self-checking bench for msdf_mult_stream (N=8), one instance per NEG_EN setting.
// Latency: first product digit expected 4 cycles after digit 1 is accepted.
// Backpressure: digits are held until in_ready; optional random input bubbles.
module tb_msdf_mult_stream;

    localparam int N = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid, in_first, neg;
    logic [1:0] x_d, y_d;

    logic       rdy  [2];
    logic       ov   [2];
    logic       ofst [2];
    logic       olst [2];
    logic [1:0] pd   [2];
    logic       bsy  [2];
    logic       er   [2];

    always #5 clk = ~clk;

    msdf_mult_stream #(.N(N), .DELTA(3), .NEG_EN(1'b0)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_first(in_first),
        .x_d(x_d), .y_d(y_d), .neg(neg), .in_ready(rdy[0]), .out_valid(ov[0]),
        .out_first(ofst[0]), .out_last(olst[0]), .p_d(pd[0]), .busy(bsy[0]), .err(er[0])
    );

    msdf_mult_stream #(.N(N), .DELTA(3), .NEG_EN(1'b1)) dut_neg (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_first(in_first),
        .x_d(x_d), .y_d(y_d), .neg(neg), .in_ready(rdy[1]), .out_valid(ov[1]),
        .out_first(ofst[1]), .out_last(olst[1]), .p_d(pd[1]), .busy(bsy[1]), .err(er[1])
    );

    typedef struct packed {
        logic signed [63:0] prod0;   // expected X*Y * 2^2N for NEG_EN=0
        logic signed [63:0] prod1;   // expected for NEG_EN=1
        logic               chk_seq;
        logic               chk_lat;
        logic [15:0]        seq;
    } exp_t;

    exp_t   sbq[$];
    int     n_cmp = 0;
    int     n_bad = 0;
    int     cyc = 0;
    int     start_cyc = 0;
    int     idx [2];
    longint pacc [2];
    logic [15:0] seqv [2];

    task automatic check_val(input string tag, input longint obs, input longint exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int dig_val(input logic [1:0] d);
        case (d)
            2'b10:   return 1;
            2'b01:   return -1;
            default: return 0;
        endcase
    endfunction

    // Digit k (1-based) lives in bits [17-2k -: 2]; value scaled by 2^N.
    function automatic longint opval(input logic [15:0] v);
        longint s = 0;
        for (int k = 1; k <= N; k++) s += longint'(dig_val(v[17-2*k -: 2])) <<< (N - k);
        return s;
    endfunction

    // Track operation starts and reset at the clock edge, as the DUT sees them.
    always @(posedge clk) begin
        if (reset === 1'b0) begin
            sbq.delete();
        end else if (in_valid && rdy[0] && in_first) begin
            // A start while an earlier operation is unfinished abandons that one.
            if (sbq.size() > 1) void'(sbq.pop_front());
            start_cyc = cyc;
            for (int d = 0; d < 2; d++) begin
                idx[d]  = 0;
                pacc[d] = 0;
                seqv[d] = '0;
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (ov[d] === 1'b1) begin
                exp_t   ex;
                longint diff;
                check_val($sformatf("p_d_legal[%0d]", d), longint'(pd[d] == 2'b11), 0);
                check_val($sformatf("out_first[%0d]", d), longint'(ofst[d]), longint'(idx[d] == 0));
                check_val($sformatf("out_last[%0d]", d), longint'(olst[d]), longint'(idx[d] == N-1));
                if (idx[d] == 0 && sbq.size() > 0 && sbq[0].chk_lat)
                    check_val($sformatf("first_latency[%0d]", d), longint'(cyc - start_cyc), 4);
                pacc[d] += longint'(dig_val(pd[d])) <<< (N - 1 - idx[d]);
                seqv[d]  = {seqv[d][13:0], pd[d]};
                idx[d]++;
                if (olst[d] === 1'b1 && sbq.size() > 0) begin
                    ex   = sbq[0];
                    diff = (d == 0 ? ex.prod0 : ex.prod1) - (pacc[d] <<< N);
                    if (diff < 0) diff = -diff;
                    check_val($sformatf("prod_err_le_lsb[%0d] P*2^8=%0d", d, pacc[d]),
                              longint'(diff <= (64'sd1 <<< N)), 1);
                    if (ex.chk_seq)
                        check_val($sformatf("digit_seq[%0d]", d), longint'(seqv[d]), longint'(ex.seq));
                    if (d == 1) void'(sbq.pop_front());
                end
            end
        end
    end

    task automatic send_digit(input logic [1:0] xd, input logic [1:0] yd,
                              input logic first, input logic ng, input int bub);
        while (bub > 0 && $urandom_range(0, 99) < bub) begin
            in_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_first = first;
        x_d      = xd;
        y_d      = yd;
        neg      = ng;
        for (int t = 0; t < 50 && rdy[0] !== 1'b1; t++) begin
            @(posedge clk);
            #1;
        end
        check_val("in_ready_wait", longint'(rdy[0]), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_first = 1'b0;
        x_d      = 2'b00;
        y_d      = 2'b00;
    endtask

    task automatic push_exp(input logic [15:0] xv, input logic [15:0] yv, input logic ng,
                            input int bub, input logic cseq, input logic [15:0] sq);
        exp_t   e;
        longint p;
        p         = opval(xv) * opval(yv);
        e.prod0   = p;
        e.prod1   = ng ? -p : p;
        e.chk_seq = cseq;
        e.chk_lat = (bub == 0);
        e.seq     = sq;
        sbq.push_back(e);
    endtask

    task automatic wait_drain(input string tag);
        for (int t = 0; t < 200 && sbq.size() != 0; t++) @(posedge clk);
        #1;
        check_val({tag, "_drained"}, longint'(sbq.size()), 0);
        check_val({tag, "_idle"}, longint'(bsy[0]), 0);
        check_val({tag, "_ready"}, longint'(rdy[0]), 1);
    endtask

    task automatic run_op(input logic [15:0] xv, input logic [15:0] yv, input logic ng,
                          input int bub, input logic cseq, input logic [15:0] sq, input string tag);
        push_exp(xv, yv, ng, bub, cseq, sq);
        for (int k = 1; k <= N; k++)
            send_digit(xv[17-2*k -: 2], yv[17-2*k -: 2], k == 1, ng, bub);
        wait_drain(tag);
    endtask

    task automatic check_reset_state(input string tag);
        for (int d = 0; d < 2; d++) begin
            check_val($sformatf("%s_out_valid[%0d]", tag, d), longint'(ov[d]), 0);
            check_val($sformatf("%s_out_first[%0d]", tag, d), longint'(ofst[d]), 0);
            check_val($sformatf("%s_out_last[%0d]", tag, d), longint'(olst[d]), 0);
            check_val($sformatf("%s_p_d[%0d]", tag, d), longint'(pd[d]), 0);
            check_val($sformatf("%s_busy[%0d]", tag, d), longint'(bsy[d]), 0);
            check_val($sformatf("%s_err[%0d]", tag, d), longint'(er[d]), 0);
            check_val($sformatf("%s_in_ready[%0d]", tag, d), longint'(rdy[d]), 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] bad_x;
        reset    = 1'b0;
        in_valid = 1'b0;
        in_first = 1'b0;
        neg      = 1'b0;
        x_d      = 2'b00;
        y_d      = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("por");
        reset = 1'b1;
        @(posedge clk);
        #1;

        // 0.5 * 0.5: selection gives +1,-1 then zeros.
        run_op(16'h8000, 16'h8000, 1'b0, 0, 1'b1, 16'h9000, "half_sq");
        // 0.5 * -0.375
        run_op(16'h8000, 16'h1400, 1'b0, 0, 1'b0, 16'h0000, "neg_y");
        // 0.99609375^2
        run_op(16'hAAAA, 16'hAAAA, 1'b0, 0, 1'b0, 16'h0000, "all_ones");
        // 0.5 * 0.5 with input bubbles: same digit sequence.
        run_op(16'h8000, 16'h8000, 1'b0, 40, 1'b1, 16'h9000, "bubbles");

        // Illegal digit at j=3, then restart as the fifth accepted digit.
        bad_x = 16'hAE00;
        push_exp(bad_x, 16'h8000, 1'b0, 0, 1'b0, 16'h0000);
        for (int k = 1; k <= 4; k++)
            send_digit(bad_x[17-2*k -: 2], (k == 1) ? 2'b10 : 2'b00, k == 1, 1'b0, 0);
        check_val("err_set[0]", longint'(er[0]), 1);
        check_val("err_set[1]", longint'(er[1]), 1);
        // 0.75 * 0.375
        run_op(16'hA000, 16'h8400, 1'b0, 0, 1'b0, 16'h0000, "restart");
        check_val("err_sticky[0]", longint'(er[0]), 1);

        // Reset held for two cycles in the middle of an operation.
        push_exp(16'hAAAA, 16'h8000, 1'b0, 0, 1'b0, 16'h0000);
        for (int k = 1; k <= 3; k++) send_digit(2'b10, 2'b10, k == 1, 1'b0, 0);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("mid_reset");
        check_val("mid_reset_sb_cleared", longint'(sbq.size()), 0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Negation honoured only by the NEG_EN=1 instance.
        run_op(16'h8000, 16'h1400, 1'b1, 0, 1'b0, 16'h0000, "neg_on");

        repeat (4) @(posedge clk);
        #1;
        check_val("no_stray_output", longint'(ov[0]), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
